// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control bundles through ID/EX, EX/MEM and MEM/WB
// and produces the pipeline hazard controls (load-use stall, branch flush,
// EX-stage forwarding selects). All stage registers clear asynchronously.
module ctrl_pipe #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_wb,
    input  logic [4:0]       id_m,
    input  logic [4:0]       id_ex,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_zero,
    output logic [4:0]       ex_ex,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [4:0]       mem_m,
    output logic [1:0]       wb_wb,
    output logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             pc_src,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // ------------------------------------------------------------------
    // Stage registers. The WB stage keeps only what is still observed
    // (valid, wb, dst); its m bundle has no consumer past MEM.
    // ------------------------------------------------------------------
    logic             ex_valid_reg,  ex_valid_next;
    logic [1:0]       ex_wb_reg,     ex_wb_next;
    logic [4:0]       ex_m_reg,      ex_m_next;
    logic [4:0]       ex_ex_reg,     ex_ex_next;
    logic [REG_W-1:0] ex_dst_reg,    ex_dst_next;
    logic [REG_W-1:0] ex_rs_reg,     ex_rs_next;
    logic [REG_W-1:0] ex_rt_reg,     ex_rt_next;

    logic             mem_valid_reg, mem_valid_next;
    logic [1:0]       mem_wb_reg,    mem_wb_next;
    logic [4:0]       mem_m_reg,     mem_m_next;
    logic [REG_W-1:0] mem_dst_reg,   mem_dst_next;

    logic             wb_valid_reg,  wb_valid_next;
    logic [1:0]       wb_wb_reg,     wb_wb_next;
    logic [REG_W-1:0] wb_dst_reg,    wb_dst_next;

    // Destination of the decode-stage instruction. Zeroed for non-writing or
    // empty slots so a don't-care RegDst can never alias a real register.
    logic [REG_W-1:0] id_dst;
    logic             load_use;
    logic             branch_taken;
    logic             kill_ex;

    assign id_dst = (id_valid & id_wb[1]) ? (id_ex[4] ? id_rd : id_rt) : '0;

    // A load in EX whose destination is read by the instruction in ID must
    // wait one cycle; the value is then picked up from MEM/WB by forwarding.
    assign load_use = ex_valid_reg & ex_m_reg[1] & (ex_dst_reg != '0) & id_valid &
                      ((ex_dst_reg == id_rs) | (ex_dst_reg == id_rt));

    // Branch resolves in MEM using the zero flag that travels with it.
    assign branch_taken = mem_valid_reg & mem_m_reg[2] & mem_zero;

    // A flush empties EX regardless of a simultaneous stall.
    assign kill_ex = branch_taken | load_use;

    assign stall  = load_use;
    assign pc_src = branch_taken;

    // ------------------------------------------------------------------
    // Forwarding: one identical selector per ALU operand. The MEM stage
    // holds the younger result, so it is checked first.
    // ------------------------------------------------------------------
    logic [1:0][REG_W-1:0] fwd_src;
    logic [1:0][1:0]       fwd_sel;

    assign fwd_src[0] = ex_rs_reg;
    assign fwd_src[1] = ex_rt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;

            assign mem_hit = mem_valid_reg & mem_wb_reg[1] & (mem_dst_reg != '0) &
                             (mem_dst_reg == fwd_src[gi]);
            assign wb_hit  = wb_valid_reg & wb_wb_reg[1] & (wb_dst_reg != '0) &
                             (wb_dst_reg == fwd_src[gi]);
            assign fwd_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    // Next-state for every stage: shift forward, inserting bubbles on kill.
    always_comb begin
        // ID -> EX, replaced by a bubble on flush or stall
        ex_valid_next  = id_valid;
        ex_wb_next     = id_wb;
        ex_m_next      = id_m;
        ex_ex_next     = id_ex;
        ex_dst_next    = id_dst;
        ex_rs_next     = id_rs;
        ex_rt_next     = id_rt;
        if (kill_ex) begin
            ex_valid_next = 1'b0;
            ex_wb_next    = '0;
            ex_m_next     = '0;
            ex_ex_next    = '0;
            ex_dst_next   = '0;
            ex_rs_next    = '0;
            ex_rt_next    = '0;
        end

        // EX -> MEM, replaced by a bubble on flush
        mem_valid_next = ex_valid_reg;
        mem_wb_next    = ex_wb_reg;
        mem_m_next     = ex_m_reg;
        mem_dst_next   = ex_dst_reg;
        if (branch_taken) begin
            mem_valid_next = 1'b0;
            mem_wb_next    = '0;
            mem_m_next     = '0;
            mem_dst_next   = '0;
        end

        // MEM -> WB, unconditional (the branch itself retires)
        wb_valid_next  = mem_valid_reg;
        wb_wb_next     = mem_wb_reg;
        wb_dst_next    = mem_dst_reg;
    end

    // Stage register update; reset empties the whole pipe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg  <= 1'b0;
            ex_wb_reg     <= '0;
            ex_m_reg      <= '0;
            ex_ex_reg     <= '0;
            ex_dst_reg    <= '0;
            ex_rs_reg     <= '0;
            ex_rt_reg     <= '0;
            mem_valid_reg <= 1'b0;
            mem_wb_reg    <= '0;
            mem_m_reg     <= '0;
            mem_dst_reg   <= '0;
            wb_valid_reg  <= 1'b0;
            wb_wb_reg     <= '0;
            wb_dst_reg    <= '0;
        end else begin
            ex_valid_reg  <= ex_valid_next;
            ex_wb_reg     <= ex_wb_next;
            ex_m_reg      <= ex_m_next;
            ex_ex_reg     <= ex_ex_next;
            ex_dst_reg    <= ex_dst_next;
            ex_rs_reg     <= ex_rs_next;
            ex_rt_reg     <= ex_rt_next;
            mem_valid_reg <= mem_valid_next;
            mem_wb_reg    <= mem_wb_next;
            mem_m_reg     <= mem_m_next;
            mem_dst_reg   <= mem_dst_next;
            wb_valid_reg  <= wb_valid_next;
            wb_wb_reg     <= wb_wb_next;
            wb_dst_reg    <= wb_dst_next;
        end
    end

    assign ex_ex  = ex_ex_reg;
    assign ex_rs  = ex_rs_reg;
    assign ex_rt  = ex_rt_reg;
    assign mem_m  = mem_m_reg;
    assign wb_wb  = wb_wb_reg;
    assign wb_dst = wb_dst_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed stimulus for ctrl_pipe with a cycle-level reference
// model of the pipe contents, a per-cycle compare process and literal
// expectations at the interesting points of each scenario.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [1:0] id_wb = '0;
    logic [4:0] id_m = '0;
    logic [4:0] id_ex = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic [4:0] id_rd = '0;
    logic       mem_zero = 1'b0;
    logic [4:0] ex_ex;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] mem_m;
    logic [1:0] wb_wb;
    logic [4:0] wb_dst;
    logic       stall;
    logic       pc_src;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    int checks = 0;
    int failures = 0;

    ctrl_pipe #(.REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wb(id_wb),
        .id_m(id_m), .id_ex(id_ex), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_zero(mem_zero), .ex_ex(ex_ex), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_m(mem_m), .wb_wb(wb_wb), .wb_dst(wb_dst), .stall(stall),
        .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // One record per in-flight instruction; slot 0=EX, 1=MEM, 2=WB.
    typedef struct packed {
        logic       valid;
        logic [1:0] wb;
        logic [4:0] m;
        logic [4:0] ex;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    instr_t pipe [3];

    function automatic instr_t decode_now();
        instr_t r;
        r.valid = id_valid;
        r.wb    = id_wb;
        r.m     = id_m;
        r.ex    = id_ex;
        r.rs    = id_rs;
        r.rt    = id_rt;
        if (id_valid && id_wb[1]) r.dst = id_ex[4] ? id_rd : id_rt;
        else                      r.dst = 5'd0;
        return r;
    endfunction

    // The instruction in ID reads a register a load in EX has not fetched yet.
    function automatic logic want_stall();
        if (!pipe[0].valid || !pipe[0].m[1] || pipe[0].dst == 5'd0 || !id_valid) return 1'b0;
        return (pipe[0].dst == id_rs) || (pipe[0].dst == id_rt);
    endfunction

    function automatic logic want_redirect();
        return pipe[1].valid && pipe[1].m[2] && mem_zero;
    endfunction

    // Nearest older writer of src among MEM (code 10) and WB (code 01).
    function automatic logic [1:0] want_fwd(input logic [4:0] src);
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].valid && pipe[s].wb[1] && pipe[s].dst != 5'd0 && pipe[s].dst == src)
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    // Advance the model one clock: retire, shift, inject bubbles on kill.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) pipe[s] <= '0;
        end else begin
            pipe[2] <= pipe[1];
            pipe[1] <= want_redirect() ? instr_t'('0) : pipe[0];
            pipe[0] <= (want_redirect() || want_stall()) ? instr_t'('0) : decode_now();
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Every cycle out of reset, compare all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ex_ex",  {3'b0, ex_ex},  {3'b0, pipe[0].ex});
            chk("ex_rs",  {3'b0, ex_rs},  {3'b0, pipe[0].rs});
            chk("ex_rt",  {3'b0, ex_rt},  {3'b0, pipe[0].rt});
            chk("mem_m",  {3'b0, mem_m},  {3'b0, pipe[1].m});
            chk("wb_wb",  {6'b0, wb_wb},  {6'b0, pipe[2].wb});
            chk("wb_dst", {3'b0, wb_dst}, {3'b0, pipe[2].dst});
            chk("stall",  {7'b0, stall},  {7'b0, want_stall()});
            chk("pc_src", {7'b0, pc_src}, {7'b0, want_redirect()});
            chk("fwd_a",  {6'b0, fwd_a},  {6'b0, want_fwd(pipe[0].rs)});
            chk("fwd_b",  {6'b0, fwd_b},  {6'b0, want_fwd(pipe[0].rt)});
        end
    end

    // ---------------- stimulus ----------------
    // Present one decode-stage instruction for the coming edge.
    task automatic cyc(input logic v, input logic [1:0] wb, input logic [4:0] m,
                       input logic [4:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z);
        @(posedge clk);
        #1;
        id_valid = v; id_wb = wb; id_m = m; id_ex = ex;
        id_rs = rs; id_rt = rt; id_rd = rd; mem_zero = z;
        #2;
        $display("cyc t=%0t v=%0b wb=%b m=%b ex=%b rs=%0d rt=%0d rd=%0d zero=%0b",
                 $time, v, wb, m, ex, rs, rt, rd, z);
    endtask

    task automatic nop();
        cyc(1'b0, 2'b00, 5'b0, 5'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // R-type ALU op writing rd
    task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        cyc(1'b1, 2'b11, 5'b00000, 5'b10100, rs, rt, rd, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) nop();
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_ex_ex",  {3'b0, ex_ex},  8'h00);
        chk("rst_mem_m",  {3'b0, mem_m},  8'h00);
        chk("rst_wb_wb",  {6'b0, wb_wb},  8'h00);
        chk("rst_stall",  {7'b0, stall},  8'h00);
        chk("rst_pc_src", {7'b0, pc_src}, 8'h00);
        chk("rst_fwd",    {4'b0, fwd_a, fwd_b}, 8'h00);
        #1 rst_n = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5 back to back
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd3, 5'd5, 5'd4);
        chk("dec_to_ex", {3'b0, ex_ex}, 8'h14);
        nop();
        chk("fwd_mem_a", {6'b0, fwd_a}, 8'h02);
        chk("fwd_mem_b", {6'b0, fwd_b}, 8'h00);
        drain();

        // one-instruction gap
        alu(5'd1, 5'd2, 5'd3);
        nop();
        alu(5'd3, 5'd5, 5'd4);
        nop();
        chk("fwd_wb_a", {6'b0, fwd_a}, 8'h01);
        drain();

        // both MEM and WB write $3: MEM wins
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd6, 5'd3, 5'd4);
        nop();
        chk("fwd_prio_b", {6'b0, fwd_b}, 8'h02);
        drain();

        // lw $2 ; add $7,$2,$6 : one-cycle load-use stall
        cyc(1'b1, 2'b10, 5'b00010, 5'b00011, 5'd1, 5'd2, 5'd0, 1'b0);
        alu(5'd2, 5'd6, 5'd7);
        chk("lu_stall", {7'b0, stall}, 8'h01);
        alu(5'd2, 5'd6, 5'd7);           // ID held by the fetch side
        chk("lu_bubble", {3'b0, ex_ex}, 8'h00);
        chk("lu_stall_end", {7'b0, stall}, 8'h00);
        nop();
        chk("lu_fwd_a", {6'b0, fwd_a}, 8'h01);
        drain();

        // beq taken in MEM kills ID and EX
        cyc(1'b1, 2'b00, 5'b00100, 5'b00010, 5'd1, 5'd2, 5'd0, 1'b0);
        alu(5'd1, 5'd2, 5'd3);
        cyc(1'b1, 2'b11, 5'b00000, 5'b10100, 5'd1, 5'd2, 5'd4, 1'b1);
        chk("br_pc_src", {7'b0, pc_src}, 8'h01);
        nop();
        chk("br_ex_ex", {3'b0, ex_ex}, 8'h00);
        chk("br_mem_m", {3'b0, mem_m}, 8'h00);
        chk("br_wb_wb", {6'b0, wb_wb}, 8'h00);
        drain();

        // beq not taken: nothing killed
        cyc(1'b1, 2'b00, 5'b00100, 5'b00010, 5'd1, 5'd2, 5'd0, 1'b0);
        alu(5'd1, 5'd2, 5'd3);
        nop();
        chk("brn_pc_src", {7'b0, pc_src}, 8'h00);
        nop();
        chk("brn_mem_m", {3'b0, mem_m}, 8'h00);
        drain();

        // sw $8 ; add $10,$8,$9 : no stall, no forward
        cyc(1'b1, 2'b00, 5'b00001, 5'b00001, 5'd1, 5'd8, 5'd0, 1'b0);
        alu(5'd8, 5'd9, 5'd10);
        chk("sw_stall", {7'b0, stall}, 8'h00);
        nop();
        chk("sw_fwd", {4'b0, fwd_a, fwd_b}, 8'h00);
        drain();

        // register 0 never stalls or forwards
        cyc(1'b1, 2'b10, 5'b00010, 5'b00011, 5'd1, 5'd0, 5'd0, 1'b0);
        alu(5'd0, 5'd0, 5'd0);
        chk("r0_stall", {7'b0, stall}, 8'h00);
        alu(5'd0, 5'd0, 5'd11);
        chk("r0_fwd", {4'b0, fwd_a, fwd_b}, 8'h00);
        nop();
        drain();

        // async reset with a full pipe
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd3, 5'd3, 5'd4);
        alu(5'd4, 5'd1, 5'd5);
        chk("pre_rst_fwd", {4'b0, fwd_a, fwd_b}, 8'h0a);
        rst_n = 1'b0;
        #1;
        chk("arst_ex_ex",  {3'b0, ex_ex},  8'h00);
        chk("arst_mem_m",  {3'b0, mem_m},  8'h00);
        chk("arst_wb_wb",  {6'b0, wb_wb},  8'h00);
        chk("arst_wb_dst", {3'b0, wb_dst}, 8'h00);
        chk("arst_fwd",    {4'b0, fwd_a, fwd_b}, 8'h00);
        chk("arst_ctl",    {6'b0, stall, pc_src}, 8'h00);
        #3 rst_n = 1'b1;
        nop();                           // first edge loads the held add $5
        chk("post_rst_ex", {3'b0, ex_ex}, 8'h14);
        chk("post_rst_rs", {3'b0, ex_rs}, 8'h04);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
